// File: rtl/lvds_rx_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lvds_rx_pkg: FSM encodings and default framing dibits for lvds_rx_frame
// Rev 1.0
// ----------------------------------------------------------------------------
package lvds_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_I_PHASE = 2'b01,
    ST_Q_PHASE = 2'b11
  } state_e;

  localparam logic [1:0] c_I_SYNC = 2'b10;
  localparam logic [1:0] c_Q_SYNC = 2'b01;

endpackage
`default_nettype wire

// File: rtl/lvds_rx_frame_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lvds_rx_frame_if: write-side bus from the frame receiver to a FIFO
// Rev 1.0
// ----------------------------------------------------------------------------
interface lvds_rx_frame_if #(
  parameter int WORD_W = 32
);
  logic              fifo_write_clk;
  logic              fifo_push;
  logic [WORD_W-1:0] fifo_data;
  logic              fifo_sync;

  modport master (output fifo_write_clk, output fifo_push, output fifo_data, output fifo_sync);
  modport slave  (input  fifo_write_clk, input  fifo_push, input  fifo_data, input  fifo_sync);
endinterface
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sat_counter: saturating event counter, synchronous clear has priority
// Rev 1.0
// ----------------------------------------------------------------------------
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  wire logic             clk_i,
  input  wire logic             rst_b_i,
  input  wire logic             inc_i,
  input  wire logic             clr_i,
  output      logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_b_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/lvds_rx_frame.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lvds_rx_frame: assembles I/Q-synced dibit frames into words for a FIFO
// Rev 1.0
// ----------------------------------------------------------------------------
module lvds_rx_frame
  import lvds_rx_pkg::*;
#(
  parameter int         WORD_W = 32,
  parameter int         CNT_W  = 16,
  parameter logic [1:0] I_SYNC = c_I_SYNC,
  parameter logic [1:0] Q_SYNC = c_Q_SYNC
) (
  input  wire logic             i_ddr_clk,
  input  wire logic             i_rst_b,
  input  wire logic [1:0]       i_ddr_data,
  input  wire logic             i_enable,
  input  wire logic             i_cnt_clear,
  input  wire logic             i_fifo_full,
  input  wire logic             i_sync_input,
  lvds_rx_frame_if.master       fifo_if,
  output      logic [CNT_W-1:0] o_frame_cnt,
  output      logic [CNT_W-1:0] o_drop_cnt,
  output      logic [CNT_W-1:0] o_sync_err_cnt,
  output      logic [1:0]       o_debug_state
);

  localparam int N     = WORD_W / 2;
  localparam int HALF  = N / 2;
  localparam int IDX_W = $clog2(N);
  localparam logic [IDX_W-1:0] c_HALF = IDX_W'(HALF);
  localparam logic [IDX_W-1:0] c_LAST = IDX_W'(N - 1);

  state_e            state_q;
  logic [IDX_W-1:0]  idx_q;
  logic [WORD_W-1:0] data_q;
  logic [WORD_W-1:0] data_d;
  logic              tag_q;
  logic              push_q;

  logic w_last;
  logic w_sync_err;

  assign data_d     = {data_q[WORD_W-3:0], i_ddr_data};
  assign w_last     = (state_q == ST_Q_PHASE) && i_enable && (idx_q == c_LAST);
  assign w_sync_err = (state_q == ST_I_PHASE) && i_enable && (idx_q == c_HALF) &&
                      (i_ddr_data != Q_SYNC);

  always_ff @(posedge i_ddr_clk) begin
    if (!i_rst_b) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      data_q  <= '0;
      tag_q   <= 1'b0;
      push_q  <= 1'b0;
    end else begin
      push_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (i_enable && (i_ddr_data == I_SYNC)) begin
            state_q <= ST_I_PHASE;
            idx_q   <= IDX_W'(1);
            tag_q   <= i_sync_input;
            data_q  <= data_d;
          end
        end
        ST_I_PHASE: begin
          if (!i_enable) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
          end else begin
            data_q <= data_d;
            if (idx_q == c_HALF) begin
              if (i_ddr_data == Q_SYNC) begin
                state_q <= ST_Q_PHASE;
                idx_q   <= idx_q + 1'b1;
              end else begin
                state_q <= ST_IDLE;
                idx_q   <= '0;
              end
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        ST_Q_PHASE: begin
          if (!i_enable) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
          end else begin
            data_q <= data_d;
            if (idx_q == c_LAST) begin
              // Full flag is sampled alongside the final dibit, push lands next cycle
              state_q <= ST_IDLE;
              idx_q   <= '0;
              push_q  <= ~i_fifo_full;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          idx_q   <= '0;
        end
      endcase
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_frame_cnt (
    .clk_i   (i_ddr_clk),
    .rst_b_i (i_rst_b),
    .inc_i   (w_last & ~i_fifo_full),
    .clr_i   (i_cnt_clear),
    .cnt_o   (o_frame_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_drop_cnt (
    .clk_i   (i_ddr_clk),
    .rst_b_i (i_rst_b),
    .inc_i   (w_last & i_fifo_full),
    .clr_i   (i_cnt_clear),
    .cnt_o   (o_drop_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_sync_err_cnt (
    .clk_i   (i_ddr_clk),
    .rst_b_i (i_rst_b),
    .inc_i   (w_sync_err),
    .clr_i   (i_cnt_clear),
    .cnt_o   (o_sync_err_cnt)
  );

  assign fifo_if.fifo_write_clk = i_ddr_clk;
  assign fifo_if.fifo_push      = push_q;
  assign fifo_if.fifo_data      = data_q;
  assign fifo_if.fifo_sync      = tag_q;
  assign o_debug_state          = state_q;

endmodule
`default_nettype wire

// File: tb/tb_lvds_rx_frame.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_lvds_rx_frame: directed frame vectors and corner sequences for lvds_rx_frame
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_lvds_rx_frame;

  logic       clk = 1'b0;
  logic       rst_b;
  logic [1:0] ddr_data;
  logic       enable;
  logic       cnt_clear;
  logic       fifo_full;
  logic       sync_in;

  logic [15:0] frame_cnt, drop_cnt, err_cnt;
  logic [1:0]  dbg_state;
  logic [2:0]  s_frame_cnt, s_drop_cnt, s_err_cnt;
  logic [1:0]  s_dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  lvds_rx_frame_if #(.WORD_W(32)) fifo_if ();
  lvds_rx_frame_if #(.WORD_W(32)) fifo_if_s ();

  always #5 clk = ~clk;

  lvds_rx_frame #(.WORD_W(32), .CNT_W(16)) dut (
    .i_ddr_clk      (clk),
    .i_rst_b        (rst_b),
    .i_ddr_data     (ddr_data),
    .i_enable       (enable),
    .i_cnt_clear    (cnt_clear),
    .i_fifo_full    (fifo_full),
    .i_sync_input   (sync_in),
    .fifo_if        (fifo_if.master),
    .o_frame_cnt    (frame_cnt),
    .o_drop_cnt     (drop_cnt),
    .o_sync_err_cnt (err_cnt),
    .o_debug_state  (dbg_state)
  );

  // Narrow-counter copy so saturation is reachable in a few frames
  lvds_rx_frame #(.WORD_W(32), .CNT_W(3)) dut_sat (
    .i_ddr_clk      (clk),
    .i_rst_b        (rst_b),
    .i_ddr_data     (ddr_data),
    .i_enable       (enable),
    .i_cnt_clear    (cnt_clear),
    .i_fifo_full    (fifo_full),
    .i_sync_input   (sync_in),
    .fifo_if        (fifo_if_s.master),
    .o_frame_cnt    (s_frame_cnt),
    .o_drop_cnt     (s_drop_cnt),
    .o_sync_err_cnt (s_err_cnt),
    .o_debug_state  (s_dbg_state)
  );

  typedef struct {
    logic [31:0] word;
    logic        full;
    logic        sync;
    logic        exp_push;
    logic        exp_sync;
    logic [15:0] exp_frame;
    logic [15:0] exp_drop;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives dibits 0..n-1 of w MSB-first, one per clock; returns #1 after the
  // last edge, i.e. inside the cycle where a full frame's push must appear.
  task automatic drive_frame(input logic [31:0] w, input int n, input logic full,
                             input logic sync, input logic clr);
    logic stray;
    stray = 1'b0;
    for (int i = 0; i < n; i++) begin
      ddr_data  = w[31-2*i -: 2];
      fifo_full = (i == n - 1) ? full : 1'b0;
      cnt_clear = (i == n - 1) ? clr : 1'b0;
      sync_in   = (i == 0) ? sync : 1'b0;
      @(posedge clk);
      #1;
      if ((i < n - 1) && fifo_if.fifo_push) stray = 1'b1;
    end
    ddr_data  = 2'b00;
    fifo_full = 1'b0;
    cnt_clear = 1'b0;
    sync_in   = 1'b0;
    chk("no_early_push", {63'd0, stray}, 64'd0);
  endtask

  initial begin
    int pushes;

    vecs[0] = '{32'h9234_5678, 1'b0, 1'b0, 1'b1, 1'b0, 16'd1, 16'd0};
    vecs[1] = '{32'hA000_7FFF, 1'b0, 1'b1, 1'b1, 1'b1, 16'd2, 16'd0};
    vecs[2] = '{32'hBEEF_4321, 1'b1, 1'b0, 1'b0, 1'b0, 16'd2, 16'd1};
    vecs[3] = '{32'h8000_4000, 1'b0, 1'b0, 1'b1, 1'b0, 16'd3, 16'd1};

    rst_b = 1'b0; ddr_data = 2'b00; enable = 1'b1;
    cnt_clear = 1'b0; fifo_full = 1'b0; sync_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_push",  {63'd0, fifo_if.fifo_push}, 64'd0);
    chk("rst_data",  {32'd0, fifo_if.fifo_data}, 64'd0);
    chk("rst_sync",  {63'd0, fifo_if.fifo_sync}, 64'd0);
    chk("rst_state", {62'd0, dbg_state}, 64'd0);
    chk("rst_cnts",  {16'd0, frame_cnt, drop_cnt, err_cnt}, 64'd0);
    rst_b = 1'b1;

    // Back-to-back frames, no idle cycles between them
    for (int v = 0; v < 4; v++) begin
      drive_frame(vecs[v].word, 16, vecs[v].full, vecs[v].sync, 1'b0);
      chk("vec_push", {63'd0, fifo_if.fifo_push}, {63'd0, vecs[v].exp_push});
      if (vecs[v].exp_push) chk("vec_data", {32'd0, fifo_if.fifo_data}, {32'd0, vecs[v].word});
      chk("vec_sync",  {63'd0, fifo_if.fifo_sync}, {63'd0, vecs[v].exp_sync});
      chk("vec_frame", {48'd0, frame_cnt}, {48'd0, vecs[v].exp_frame});
      chk("vec_drop",  {48'd0, drop_cnt},  {48'd0, vecs[v].exp_drop});
    end
    @(posedge clk); #1;
    chk("push_single_cycle", {63'd0, fifo_if.fifo_push}, 64'd0);

    // Bad Q-sync at dibit 8, then a good frame straight after
    drive_frame(32'h9234_C678, 9, 1'b0, 1'b0, 1'b0);
    chk("qerr_cnt",   {48'd0, err_cnt}, 64'd1);
    chk("qerr_state", {62'd0, dbg_state}, 64'd0);
    drive_frame(32'h9234_5678, 16, 1'b0, 1'b0, 1'b0);
    chk("qerr_next_push",  {63'd0, fifo_if.fifo_push}, 64'd1);
    chk("qerr_next_data",  {32'd0, fifo_if.fifo_data}, 64'h9234_5678);
    chk("qerr_next_frame", {48'd0, frame_cnt}, 64'd4);

    // Enable dropped mid-frame
    drive_frame(32'h9234_5678, 6, 1'b0, 1'b0, 1'b0);
    ddr_data = 2'b01; enable = 1'b0;
    @(posedge clk); #1;
    chk("abort_state", {62'd0, dbg_state}, 64'd0);
    enable = 1'b1; ddr_data = 2'b00;
    pushes = 0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      if (fifo_if.fifo_push) pushes++;
    end
    chk("abort_no_push", 64'(pushes), 64'd0);
    chk("abort_cnts", {16'd0, frame_cnt, drop_cnt, err_cnt}, {16'd0, 16'd4, 16'd1, 16'd1});

    // Reset held low at dibit 5
    drive_frame(32'h9234_5678, 5, 1'b0, 1'b0, 1'b0);
    rst_b = 1'b0; ddr_data = 2'b01;
    @(posedge clk); #1;
    chk("mrst_push",  {63'd0, fifo_if.fifo_push}, 64'd0);
    chk("mrst_data",  {32'd0, fifo_if.fifo_data}, 64'd0);
    chk("mrst_state", {62'd0, dbg_state}, 64'd0);
    chk("mrst_cnts",  {16'd0, frame_cnt, drop_cnt, err_cnt}, 64'd0);
    rst_b = 1'b1;
    drive_frame(32'hA000_7FFF, 16, 1'b0, 1'b1, 1'b0);
    chk("mrst_next_push",  {63'd0, fifo_if.fifo_push}, 64'd1);
    chk("mrst_next_data",  {32'd0, fifo_if.fifo_data}, 64'hA000_7FFF);
    chk("mrst_next_sync",  {63'd0, fifo_if.fifo_sync}, 64'd1);
    chk("mrst_next_frame", {48'd0, frame_cnt}, 64'd1);

    // Clear coinciding with a frame-count increment
    drive_frame(32'h9234_5678, 16, 1'b0, 1'b0, 1'b1);
    chk("clr_push",  {63'd0, fifo_if.fifo_push}, 64'd1);
    chk("clr_frame", {48'd0, frame_cnt}, 64'd0);
    drive_frame(32'h9234_5678, 16, 1'b0, 1'b0, 1'b0);
    chk("clr_resume", {48'd0, frame_cnt}, 64'd1);

    // Saturation: narrow counter stops at all-ones
    cnt_clear = 1'b1;
    @(posedge clk); #1;
    cnt_clear = 1'b0;
    for (int f = 0; f < 9; f++) drive_frame(32'h9234_5678, 16, 1'b0, 1'b0, 1'b0);
    chk("sat_small", {61'd0, s_frame_cnt}, 64'd7);
    chk("sat_wide",  {48'd0, frame_cnt}, 64'd9);
    @(posedge clk); #1;
    chk("sat_hold", {61'd0, s_frame_cnt}, 64'd7);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lvds_rx_frame.md
LVDS_RX_FRAME -- requirements
Module: lvds_rx_frame

Interface
REQ-001 Param WORD_W, default 32, pushed word width; legal values are multiples of 4 in the range 8..64. Derived: N = WORD_W/2 dibits per frame, HALF = N/2.
REQ-002 Param CNT_W, default 16, width of each statistics counter.
REQ-003 Param I_SYNC, default 2'b10, first dibit of the frame.
REQ-004 Param Q_SYNC, default 2'b01, dibit at index HALF.
REQ-005 Ports:
- i_ddr_clk  in  1  sole clock.
- i_rst_b  in  1  reset; synchronous, active-low.
- i_ddr_data  in  2  deserialized dibit per clock.
- i_enable  in  1  receive enable.
- i_cnt_clear  in  1  synchronous clear of all counters.
- i_fifo_full  in  1  downstream FIFO full.
- i_sync_input  in  1  external timestamp/sync marker.
- o_fifo_write_clk  out  1  equals i_ddr_clk.
- o_fifo_push  out  1  one-cycle write strobe.
- o_fifo_data  out  WORD_W  assembled frame.
- o_fifo_sync  out  1  sync tag of the pushed frame.
- o_frame_cnt  out  CNT_W  frames pushed.
- o_drop_cnt  out  CNT_W  frames dropped because the FIFO was full.
- o_sync_err_cnt  out  CNT_W  Q-sync misses.
- o_debug_state  out  2  current FSM state.

Function
REQ-006 FSM states and encodings: IDLE=2'b00, I_PHASE=2'b01, Q_PHASE=2'b11. o_debug_state equals the state register.
REQ-007 IDLE, i_enable=1 and i_ddr_data==I_SYNC: go to I_PHASE, load dibit index 1, capture i_sync_input into the tag register. Otherwise stay in IDLE.
REQ-008 The frame is shifted MSB-first: o_fifo_data <= {o_fifo_data[WORD_W-3:0], i_ddr_data} on every cycle the FSM accepts a dibit, sync dibits included. Dibit 0 lands in [WORD_W-1:WORD_W-2].
REQ-009 I_PHASE index HALF:
- i_ddr_data==Q_SYNC: go to Q_PHASE.
- Otherwise: go to IDLE and increment o_sync_err_cnt.
REQ-010 Q_PHASE index N-1:
- Shift the dibit and go to IDLE.
- Next cycle, o_fifo_push=~i_fifo_full, using i_fifo_full as sampled in that final cycle.
- Push: o_frame_cnt++. No push: o_drop_cnt++.
REQ-011 Latency: I_SYNC dibit at cycle t0 gives o_fifo_push high exactly in cycle t0+N, with o_fifo_data and o_fifo_sync valid in that cycle only.
REQ-012 Back-to-back frames with zero idle cycles are accepted. The IDLE cycle that carries the push also evaluates the next I_SYNC.
REQ-013 o_fifo_push is never high for two consecutive cycles, and never high outside the cycle defined in REQ-011.
REQ-014 i_enable=0 in I_PHASE or Q_PHASE: abort to IDLE on the next edge; no push, no counter increment.
REQ-015 Counters saturate at all-ones. When i_cnt_clear and an increment occur in the same cycle, clear wins. Clear does not affect the FSM.
REQ-016 A false I_SYNC inside payload while in IDLE is resolved only by the REQ-009 check; there is no look-ahead.

Reset
REQ-017 With i_rst_b=0 at a clock edge:
- State -> IDLE, dibit index -> 0.
- o_fifo_push, o_fifo_sync -> 0; o_fifo_data -> 0.
- All counters -> 0.
REQ-018 Reset asserted mid-frame discards the frame: no push, no counter change. The first legal I_SYNC may arrive on the first edge after release.

Structure
REQ-019 Package lvds_rx_pkg holds the state encodings and the default I_SYNC/Q_SYNC constants.
REQ-020 Sub-module sat_counter (parameter CNT_W; inputs inc and clr) is instantiated three times.

Verification
REQ-021 Setup for all scenarios: WORD_W=32 (N=16), stream 0x9234_5678 MSB-first with full=0, frame starting at t0.
REQ-022 Single frame per REQ-021 -> push in t0+16, data=0x9234_5678, frame_cnt=1.
REQ-023 Two back-to-back frames 0x9234_5678 then 0xA000_7FFF -> two pushes 16 cycles apart, in order.
REQ-024 Dibit 8 = 2'b11 -> no push, sync_err_cnt=1; a valid frame immediately after still pushes.
REQ-025 i_fifo_full=1 in the last dibit cycle -> no push, drop_cnt=1, frame_cnt unchanged.
REQ-026 Remaining scenarios:
- Reset held low at dibit 5 -> no push, all outputs 0.
- i_sync_input=1 only at t0 -> o_fifo_sync=1 with push.
- Counters forced to 0xFFFF -> stay 0xFFFF.
